imm_decode_pipe: RTL
====================

Name: imm_decode_pipe

Overview:
- Registered, parametrised successor to the combinational immediate generator. Sits between fetch and register-read.
- Accepts one 32-bit instruction plus PC per valid/ready transfer. Extracts opcode/funct fields and computes an XLEN-wide immediate with a type tag and an illegal flag.
- Outputs are registered, with an optional skid buffer so fetch is never combinationally stalled by downstream ready.
- Supports RV32I and RV64I (6-bit shamt, OP-IMM-32).

Parameters:
XLEN, 32, data width; legal values 32 or 64; immediates sign-extended to XLEN.
SKID, 1, 1 = 2-entry output+skid buffer with registered in_ready; 0 = single output register with combinational in_ready.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset; asynchronous and active-high.
flush  input  1  synchronous kill of all buffered entries.
in_valid  input  1  upstream instruction valid.
in_ready  output  1  block can accept this cycle.
in_instr  input  32  instruction word.
in_pc  input  XLEN  instruction PC, passed through.
out_valid  output  1  output entry valid.
out_ready  input  1  downstream accepts.
out_instr  output  32  registered instruction.
out_pc  output  XLEN  registered PC.
out_opcode  output  7  instr[6:0].
out_funct3  output  3  instr[14:12].
out_funct7  output  7  instr[31:25].
out_imm  output  XLEN  selected immediate.
out_imm_type  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.
out_illegal  output  1  opcode not supported, or all-zero instruction.

Behaviour:
- Reset, asynchronous: out_valid=0, skid_valid=0, all data outputs 0, out_imm_type=0, out_illegal=0, in_ready=1.
- Reset asserted mid-transfer drops every entry; nothing is replayed.
- Transfer in: in_valid & in_ready at the edge. Transfer out: out_valid & out_ready at the edge.
- Latency: an accepted instruction appears on out_* at the next edge, provided the output register is empty or is draining that cycle.
- Stability: while out_valid & !out_ready, all out_* hold stable.
- Immediates, computed from in_instr before registering:
  - I: sign-extend instr[31:20].
  - S: sign-extend {instr[31:25], instr[11:7]}.
  - B: sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
  - J: sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Selection by opcode:
  - OP-IMM 0010011 with funct3 001 or 101: SHAMT, zero-extended; width instr[24:20] if XLEN=32, instr[25:20] if XLEN=64.
  - Other OP-IMM, LOAD 0000011, JALR 1100111: I.
  - STORE 0100011: S. BRANCH 1100011: B. JAL 1101111: J. LUI 0110111 and AUIPC 0010111: U.
  - OP 0110011: NONE, imm 0.
  - OP-IMM-32 0011011 (XLEN=64 only): funct3 001/101 gives SHAMT from instr[24:20]; otherwise I.
  - Any other opcode, or 0011011 when XLEN=32: illegal=1, type NONE, imm 0.
  - in_instr == 0: illegal=1.
- SKID=1:
  - in_ready = !skid_valid (registered).
  - Accept while out_valid & !out_ready: entry goes to the skid register and skid_valid=1.
  - Output drains while skid_valid: skid entry moves to the output register, skid_valid=0. A new input is not accepted that cycle, because in_ready was 0.
  - Output empty or draining, skid empty: the new input goes directly to the output register.
  - Ordering is strictly FIFO.
- SKID=0: in_ready = !out_valid | out_ready (combinational).
- flush:
  - At the edge: out_valid=0, skid_valid=0. Any input accepted in the same cycle is discarded.
  - in_ready=1 the following cycle.
  - flush has priority over all transfers.
  - Data registers need not be cleared.
- out_valid, skid_valid and in_ready never carry X after reset.

Test Plan:
- XLEN=32, instr 0xFFF00093 (addi x1,x0,-1) -> next cycle out_imm=0xFFFFFFFF, type=1, illegal=0, out_opcode=0x13.
- XLEN=64, instr 0x800002B7 (lui x5,0x80000) -> out_imm=0xFFFFFFFF80000000, type=4. Instr 0x123452B7 -> 0x0000000012345000.
- XLEN=64, instr 0x02109093 (slli x1,x1,33) -> out_imm=0x21, type=6. Same word with XLEN=32 -> out_imm=0x01, type=6.
- SKID=1 backpressure: out_ready=0, send A=0xFFF00093 then B=0x123452B7 on consecutive cycles.
  - Required: in_ready=0 from the cycle after B is accepted; out_* holds A.
  - Raise out_ready: A, then B on the next cycle, then in_ready=1. No loss or duplication.
- flush: with A in output and B in skid, assert flush for one cycle while in_valid=1 with C.
  - Required: next cycle out_valid=0 and in_ready=1; A, B and C never appear.
- Illegal/reset: instr 0x0000007F -> illegal=1, imm=0, type=0. Instr 0x00000000 -> illegal=1. Assert rst asynchronously mid-stall -> out_valid=0 immediately, in_ready=1.

Source files
------------

// File: rtl/imm_decode_pipe.sv
// Registered RV32I/RV64I field + immediate decoder between fetch and register-read; 1-cycle latency.
// Backpressure: SKID=1 parks one entry in a skid register (in_ready registered), SKID=0 uses combinational in_ready.
module imm_decode_pipe #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_type,
  output logic            out_illegal
);

  localparam logic [2:0] T_NONE  = 3'd0;
  localparam logic [2:0] T_I     = 3'd1;
  localparam logic [2:0] T_S     = 3'd2;
  localparam logic [2:0] T_B     = 3'd3;
  localparam logic [2:0] T_U     = 3'd4;
  localparam logic [2:0] T_J     = 3'd5;
  localparam logic [2:0] T_SHAMT = 3'd6;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      imm_type;
    logic            illegal;
  } entry_t;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic            is_shift;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm_sh32;
  logic [XLEN-1:0] sel_imm;
  logic [2:0]      sel_type;
  logic            sel_ill;
  entry_t          dec, out_q, skid_q;
  logic            skid_valid;
  logic            in_xfer;

  assign opc      = in_instr[6:0];
  assign f3       = in_instr[14:12];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  assign imm_i    = XLEN'($signed(in_instr[31:20]));
  assign imm_s    = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b    = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign imm_u    = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j    = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
  // RV64 shifts carry a 6-bit shamt; the *W forms stay at 5 bits.
  assign imm_sh   = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
  assign imm_sh32 = XLEN'(in_instr[24:20]);

  always_comb begin
    sel_imm  = '0;
    sel_type = T_NONE;
    sel_ill  = 1'b0;
    case (opc)
      OPC_OP_IMM: begin
        if (is_shift) begin
          sel_imm  = imm_sh;
          sel_type = T_SHAMT;
        end else begin
          sel_imm  = imm_i;
          sel_type = T_I;
        end
      end
      OPC_LOAD, OPC_JALR: begin
        sel_imm  = imm_i;
        sel_type = T_I;
      end
      OPC_STORE: begin
        sel_imm  = imm_s;
        sel_type = T_S;
      end
      OPC_BRANCH: begin
        sel_imm  = imm_b;
        sel_type = T_B;
      end
      OPC_JAL: begin
        sel_imm  = imm_j;
        sel_type = T_J;
      end
      OPC_LUI, OPC_AUIPC: begin
        sel_imm  = imm_u;
        sel_type = T_U;
      end
      OPC_OP: begin
        sel_imm  = '0;
        sel_type = T_NONE;
      end
      OPC_OP_IMM_32: begin
        if (XLEN != 64) begin
          sel_ill = 1'b1;
        end else if (is_shift) begin
          sel_imm  = imm_sh32;
          sel_type = T_SHAMT;
        end else begin
          sel_imm  = imm_i;
          sel_type = T_I;
        end
      end
      default: sel_ill = 1'b1;
    endcase
    if (in_instr == 32'd0) begin
      sel_imm  = '0;
      sel_type = T_NONE;
      sel_ill  = 1'b1;
    end
  end

  assign dec.instr    = in_instr;
  assign dec.pc       = in_pc;
  assign dec.imm      = sel_imm;
  assign dec.imm_type = sel_type;
  assign dec.illegal  = sel_ill;

  assign in_ready = (SKID != 0) ? !skid_valid : (!out_valid || out_ready);
  assign in_xfer  = in_valid && in_ready;

  // With SKID=0 in_xfer implies the output is free, so the skid branch is unreachable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (out_ready) begin
        out_q      <= skid_q;
        skid_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      if (!out_valid || out_ready) begin
        out_q     <= dec;
        out_valid <= 1'b1;
      end else begin
        skid_q     <= dec;
        skid_valid <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_instr    = out_q.instr;
  assign out_pc       = out_q.pc;
  assign out_opcode   = out_q.instr[6:0];
  assign out_funct3   = out_q.instr[14:12];
  assign out_funct7   = out_q.instr[31:25];
  assign out_imm      = out_q.imm;
  assign out_imm_type = out_q.imm_type;
  assign out_illegal  = out_q.illegal;

endmodule
